// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory arbiter.
//   owner_e         : which port owns the read data returning next cycle
//   DEF_STREAK_MAX  : default cap on consecutive contended load/store grants
package mem_arbiter_pkg;

   localparam int unsigned DEF_STREAK_MAX = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous memory.
// Load/store normally wins contention; fetch is forced through after
// STREAK_MAX consecutive contended load/store grants.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   if_req/if_addr/if_flush       fetch request, word address, cancel pending data
//   if_gnt/if_rvalid/if_rdata     fetch accept, read data valid, read data
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata  load/store request side
//   ls_gnt/ls_rvalid/ls_rdata     load/store accept, load data valid, load data
//   mem_addr/mem_wdata/mem_wes    memory address, write data, per-lane write enables
//   mem_rdata                     registered memory read data (1-cycle latency)
//
// Read owner register:
//   state    | meaning
//   OWN_NONE | no read data returns next cycle
//   OWN_IF   | returning data belongs to the fetch port
//   OWN_LS   | returning data belongs to a load
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int M_WIDTH    = 32,
   parameter int A_WIDTH    = 30,
   parameter int STREAK_MAX = DEF_STREAK_MAX
) (
   input  logic                 clk,
   input  logic                 rst_n,

   input  logic                 if_req,
   input  logic [A_WIDTH-1:0]   if_addr,
   input  logic                 if_flush,
   output logic                 if_gnt,
   output logic                 if_rvalid,
   output logic [M_WIDTH-1:0]   if_rdata,

   input  logic                 ls_req,
   input  logic                 ls_we,
   input  logic [M_WIDTH/8-1:0] ls_be,
   input  logic [A_WIDTH-1:0]   ls_addr,
   input  logic [M_WIDTH-1:0]   ls_wdata,
   output logic                 ls_gnt,
   output logic                 ls_rvalid,
   output logic [M_WIDTH-1:0]   ls_rdata,

   output logic [A_WIDTH-1:0]   mem_addr,
   output logic [M_WIDTH-1:0]   mem_wdata,
   output logic [M_WIDTH/8-1:0] mem_wes,
   input  logic [M_WIDTH-1:0]   mem_rdata
);

   localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
   localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

   logic [SW-1:0] streak;
   logic [SW-1:0] streak_nxt;
   owner_e        owner;
   owner_e        owner_nxt;
   logic          flush_pend;
   logic          fetch_forced;

   // Grants are purely combinational so they keep working during reset;
   // only the write strobes are gated by rst_n.
   always_comb begin
      fetch_forced = if_req && (streak == STREAK_TOP);
      ls_gnt       = ls_req && !fetch_forced;
      if_gnt       = if_req && !ls_gnt;
   end

   assign mem_addr  = ls_gnt ? ls_addr : if_addr;
   assign mem_wdata = ls_wdata;
   assign mem_wes   = (ls_gnt && ls_we && rst_n) ? ls_be : '0;

   // Streak only counts grants that actually made fetch wait.
   always_comb begin
      streak_nxt = streak;
      if (!if_req || if_gnt) begin
         streak_nxt = '0;
      end else if (ls_gnt && (streak != STREAK_TOP)) begin
         streak_nxt = streak + SW'(1);
      end
   end

   // Store grants return nothing, so they leave the owner at NONE.
   always_comb begin
      owner_nxt = OWN_NONE;
      if (if_gnt) begin
         owner_nxt = OWN_IF;
      end else if (ls_gnt && !ls_we) begin
         owner_nxt = OWN_LS;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak     <= '0;
         owner      <= OWN_NONE;
         flush_pend <= 1'b0;
      end else begin
         streak     <= streak_nxt;
         owner      <= owner_nxt;
         flush_pend <= if_flush;
      end
   end

   // A flush kills whatever fetch data arrives on the following cycle,
   // including data for a fetch granted in the same cycle as the flush.
   assign if_rvalid = (owner == OWN_IF) && !flush_pend;
   assign ls_rvalid = (owner == OWN_LS);
   assign if_rdata  = mem_rdata;
   assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and a read-return
// scoreboard checked by an independent monitor.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [29:0] if_addr;
   logic        if_flush;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [3:0]  ls_be;
   logic [29:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wes;
   logic [31:0] mem_rdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      bit          port;   // 0 = fetch, 1 = load/store
      logic [31:0] data;
      int          due;
   } rd_t;
   rd_t sb[$];

   mem_arbiter #(.M_WIDTH(32), .A_WIDTH(30), .STREAK_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
      .ls_rdata(ls_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wes(mem_wes),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered, read-before-write memory; word i preloads to 0xA000_0000|i,
   // except word 0x38 which holds 0x1122_3344.
   logic [31:0] mem [64];
   bit          loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | i;
         mem[6'h38] <= 32'h1122_3344;
         loaded <= 1'b1;
      end else begin
         mem_rdata <= mem[mem_addr[5:0]];
         for (int b = 0; b < 4; b++)
            if (mem_wes[b]) mem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic expect_read(input bit port, input logic [31:0] data);
      rd_t e;
      e.port = port;
      e.data = data;
      e.due  = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic drive(input bit ir, input logic [29:0] ia, input bit fl,
                        input bit lr, input bit we, input logic [3:0] be,
                        input logic [29:0] la, input logic [31:0] wd);
      if_req   = ir;
      if_addr  = ia;
      if_flush = fl;
      ls_req   = lr;
      ls_we    = we;
      ls_be    = be;
      ls_addr  = la;
      ls_wdata = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_gnt(input string name, input bit exp_if, input bit exp_ls);
      chk({name, "_if_gnt"}, {31'd0, if_gnt}, {31'd0, exp_if});
      chk({name, "_ls_gnt"}, {31'd0, ls_gnt}, {31'd0, exp_ls});
   endtask

   // Monitor: every rvalid must match the oldest outstanding expectation in
   // exactly its due cycle; a due expectation without rvalid is also an error.
   always @(negedge clk) begin
      rd_t e;
      if (if_rvalid || ls_rvalid) begin
         if (sb.size() == 0 || sb[0].due != cyc) begin
            total++;
            bad++;
            $display("FAIL rvalid_unexpected cyc=%0d if_rvalid=%0b ls_rvalid=%0b want none",
                     cyc, if_rvalid, ls_rvalid);
         end else begin
            e = sb.pop_front();
            chk("rvalid_port", {30'd0, if_rvalid, ls_rvalid}, e.port ? 32'd1 : 32'd2);
            chk("rdata", e.port ? ls_rdata : if_rdata, e.data);
         end
      end else if (sb.size() != 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         total++;
         bad++;
         $display("FAIL rvalid_missing cyc=%0d got=none want port=%0d data=%h",
                  cyc, e.port, e.data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   bit exp_ls_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

   initial begin
      rst_n = 1'b0;
      drive(0, 30'h0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
      chk_gnt("rst_idle", 0, 0);
      tick();
      rst_n = 1'b1;

      // Back-to-back fetches.
      drive(1, 30'h10, 0, 0, 0, 4'h0, 30'h0, 32'h0);
      @(negedge clk);
      chk_gnt("fetch0", 1, 0);
      chk("fetch0_addr", {2'b0, mem_addr}, 32'h10);
      expect_read(0, 32'hA000_0010);
      tick();
      drive(1, 30'h11, 0, 0, 0, 4'h0, 30'h0, 32'h0);
      @(negedge clk);
      chk_gnt("fetch1", 1, 0);
      chk("fetch1_addr", {2'b0, mem_addr}, 32'h11);
      expect_read(0, 32'hA000_0011);
      tick();

      // No request: fetch address still drives the memory.
      drive(0, 30'h05, 0, 0, 0, 4'h0, 30'h2A, 32'h0);
      @(negedge clk);
      chk_gnt("idle", 0, 0);
      chk("idle_addr", {2'b0, mem_addr}, 32'h05);
      tick();

      // Partial store then load of the same word.
      drive(0, 30'h0, 0, 1, 1, 4'b0011, 30'h38, 32'hAABB_CCDD);
      @(negedge clk);
      chk_gnt("store", 0, 1);
      chk("store_wes", {28'd0, mem_wes}, 32'h3);
      chk("store_addr", {2'b0, mem_addr}, 32'h38);
      chk("store_wdata", mem_wdata, 32'hAABB_CCDD);
      tick();
      drive(0, 30'h0, 0, 1, 0, 4'hF, 30'h38, 32'h0);
      @(negedge clk);
      chk_gnt("load", 0, 1);
      chk("load_wes", {28'd0, mem_wes}, 32'h0);
      expect_read(1, 32'h1122_CCDD);
      tick();
      drive(0, 30'h0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
      tick();

      // Sustained contention: fetch forced after four load grants.
      for (int i = 0; i < 10; i++) begin
         drive(1, 30'h20, 0, 1, 0, 4'hF, 30'h30, 32'h0);
         @(negedge clk);
         chk_gnt($sformatf("contend%0d", i), !exp_ls_seq[i], exp_ls_seq[i]);
         chk($sformatf("contend%0d_addr", i), {2'b0, mem_addr},
             exp_ls_seq[i] ? 32'h30 : 32'h20);
         expect_read(exp_ls_seq[i], exp_ls_seq[i] ? 32'hA000_0030 : 32'hA000_0020);
         tick();
      end

      // Flush drops a same-cycle fetch; the next fetch returns normally.
      drive(1, 30'h24, 1, 0, 0, 4'h0, 30'h0, 32'h0);
      @(negedge clk);
      chk_gnt("flush_fetch", 1, 0);
      tick();
      drive(1, 30'h25, 0, 0, 0, 4'h0, 30'h0, 32'h0);
      @(negedge clk);
      chk_gnt("post_flush_fetch", 1, 0);
      expect_read(0, 32'hA000_0025);
      tick();
      drive(0, 30'h0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
      tick();

      // Load granted, then reset asserted before its data returns.
      drive(0, 30'h0, 0, 1, 0, 4'hF, 30'h3A, 32'h0);
      @(negedge clk);
      chk_gnt("rst_load", 0, 1);
      rst_n = 1'b0;
      tick();
      drive(0, 30'h0, 0, 1, 1, 4'hF, 30'h3A, 32'hDEAD_BEEF);
      @(negedge clk);
      chk_gnt("rst_store", 0, 1);
      chk("rst_store_wes", {28'd0, mem_wes}, 32'h0);
      chk("rst_ls_rvalid_held", {31'd0, ls_rvalid}, 32'd0);
      tick();
      rst_n = 1'b1;
      drive(0, 30'h0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
      @(negedge clk);
      chk("post_rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
      tick();

      // The store attempted under reset must not have reached memory.
      drive(0, 30'h0, 0, 1, 0, 4'hF, 30'h3A, 32'h0);
      @(negedge clk);
      chk_gnt("reload", 0, 1);
      expect_read(1, 32'hA000_003A);
      tick();
      drive(0, 30'h0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
      repeat (3) tick();

      chk("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
